kamus_mem_lsu: RTL

KAMUS_MEM_LSU -- requirements
Module: kamus_mem_lsu

---
 rtl/kamus_mem_lsu.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/kamus_mem_lsu.sv
// MEM-stage load/store unit: issues L1D requests from EX/MEM, stalls the pipe
// while a request is outstanding, aligns load data and fills the MEM/WB register.
module kamus_mem_lsu #(
  parameter int XLEN    = 32,
  parameter int RF_AW   = 5,
  parameter int WBSEL_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_exmem_i,
  input  logic                 ld_exmem_i,
  input  logic                 st_exmem_i,
  input  logic [2:0]           funct3_exmem_i,
  input  logic [XLEN-1:0]      alu_rslt_exmem_i,
  input  logic [XLEN-1:0]      rs2_exmem_i,
  input  logic                 regfile_wr_en_exmem_i,
  input  logic [WBSEL_W-1:0]   wb_mux_sel_exmem_i,
  input  logic [RF_AW-1:0]     rd_addr_exmem_i,
  output logic                 stall_o,
  output logic                 valid_memwb_o,
  output logic                 regfile_wr_en_memwb_o,
  output logic                 misalign_memwb_o,
  output logic [XLEN-1:0]      alu_memwb_o,
  output logic [XLEN-1:0]      l1d_rd_data_memwb_o,
  output logic [WBSEL_W-1:0]   wb_mux_sel_memwb_o,
  output logic [RF_AW-1:0]     rd_addr_memwb_o,
  output logic                 l1d_req_o,
  output logic                 l1d_we_o,
  output logic [XLEN/8-1:0]    l1d_be_o,
  output logic [XLEN-1:0]      l1d_addr_o,
  output logic [XLEN-1:0]      l1d_wr_data_o,
  input  logic                 l1d_gnt_i,
  input  logic                 l1d_rvalid_i,
  input  logic [XLEN-1:0]      l1d_rd_data_i
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  state_t            r_state, w_next;
  logic [OFFW-1:0]   r_off;
  logic [2:0]        r_f3;

  logic              w_is_mem, w_bad_f3, w_unal, w_misalign, w_memop;
  logic              w_issue, w_done, w_ld_done, w_stall;
  logic [1:0]        w_size;
  logic [OFFW-1:0]   w_off;
  logic [NB-1:0]     w_mask;
  logic [XLEN-1:0]   w_wd, w_shift, w_ld_data;

  assign w_size   = funct3_exmem_i[1:0];
  assign w_off    = alu_rslt_exmem_i[OFFW-1:0];
  assign w_is_mem = valid_exmem_i & (ld_exmem_i | st_exmem_i);

  // Doubleword/wu codes have no meaning on a 32-bit datapath, so they fault like a misalignment.
  assign w_bad_f3 = (funct3_exmem_i == 3'b111) |
                    ((XLEN == 32) & ((funct3_exmem_i == 3'b011) | (funct3_exmem_i == 3'b110)));

  always_comb begin
    w_unal = 1'b0;
    case (w_size)
      2'd1:    w_unal = alu_rslt_exmem_i[0];
      2'd2:    w_unal = |alu_rslt_exmem_i[1:0];
      2'd3:    w_unal = |alu_rslt_exmem_i[2:0];
      default: w_unal = 1'b0;
    endcase
  end

  assign w_misalign = w_is_mem & (w_bad_f3 | w_unal);
  assign w_memop    = w_is_mem & ~w_misalign;
  assign w_issue    = (r_state != WAIT_RVALID);
  assign w_ld_done  = (r_state == WAIT_RVALID) & l1d_rvalid_i;
  assign w_done     = w_memop & ((w_issue & l1d_gnt_i & st_exmem_i) | w_ld_done);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, WAIT_GNT: begin
        if (!w_memop)        w_next = IDLE;
        else if (l1d_gnt_i)  w_next = st_exmem_i ? IDLE : WAIT_RVALID;
        else                 w_next = WAIT_GNT;
      end
      WAIT_RVALID: if (l1d_rvalid_i) w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  // Output logic; request fields derive from held EX/MEM inputs, so they stay stable until grant
  always_comb begin
    w_mask = '1;
    case (w_size)
      2'd0:    w_mask = NB'(1);
      2'd1:    w_mask = NB'(3);
      2'd2:    w_mask = NB'(15);
      default: w_mask = '1;
    endcase
    w_wd = '0;
    for (int i = 0; i < NB; i++) begin
      case (w_size)
        2'd0:    w_wd[i*8 +: 8] = rs2_exmem_i[7:0];
        2'd1:    w_wd[i*8 +: 8] = rs2_exmem_i[(i%2)*8 +: 8];
        2'd2:    w_wd[i*8 +: 8] = rs2_exmem_i[(i%4)*8 +: 8];
        default: w_wd[i*8 +: 8] = rs2_exmem_i[i*8 +: 8];
      endcase
    end
    w_stall       = rst_ni & w_memop & ~w_done;
    stall_o       = w_stall;
    l1d_req_o     = rst_ni & w_memop & w_issue;
    l1d_we_o      = st_exmem_i;
    l1d_be_o      = st_exmem_i ? (w_mask << w_off) : '1;
    l1d_addr_o    = {alu_rslt_exmem_i[XLEN-1:OFFW], {OFFW{1'b0}}};
    l1d_wr_data_o = w_wd;
  end

  // Lane offset and size are latched at grant for the response that follows
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_off <= '0;
      r_f3  <= '0;
    end else if (w_memop & w_issue & l1d_gnt_i) begin
      r_off <= w_off;
      r_f3  <= funct3_exmem_i;
    end
  end

  assign w_shift = l1d_rd_data_i >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = w_shift;
    case (r_f3)
      3'b000:  w_ld_data = XLEN'($signed(w_shift[7:0]));
      3'b001:  w_ld_data = XLEN'($signed(w_shift[15:0]));
      3'b010:  w_ld_data = XLEN'($signed(w_shift[31:0]));
      3'b100:  w_ld_data = XLEN'(w_shift[7:0]);
      3'b101:  w_ld_data = XLEN'(w_shift[15:0]);
      3'b110:  w_ld_data = XLEN'(w_shift[31:0]);
      default: w_ld_data = w_shift;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_memwb_o         <= 1'b0;
      regfile_wr_en_memwb_o <= 1'b0;
      misalign_memwb_o      <= 1'b0;
      alu_memwb_o           <= '0;
      l1d_rd_data_memwb_o   <= '0;
      wb_mux_sel_memwb_o    <= '0;
      rd_addr_memwb_o       <= '0;
    end else if (w_stall) begin
      valid_memwb_o         <= 1'b0;
      regfile_wr_en_memwb_o <= 1'b0;
      misalign_memwb_o      <= 1'b0;
    end else begin
      valid_memwb_o         <= valid_exmem_i;
      regfile_wr_en_memwb_o <= regfile_wr_en_exmem_i & ~w_misalign;
      misalign_memwb_o      <= w_misalign;
      alu_memwb_o           <= alu_rslt_exmem_i;
      wb_mux_sel_memwb_o    <= wb_mux_sel_exmem_i;
      rd_addr_memwb_o       <= rd_addr_exmem_i;
      if (w_ld_done) l1d_rd_data_memwb_o <= w_ld_data;
    end
  end

endmodule
